// File: rtl/sm_mul_driver.sv
// Sequencer around the 8-bit sign-magnitude multiplier: buffers operand pairs, runs the bgn/ibus load, returns the 16-bit product.
// Latency: mul_bgn one cycle after the FIFO becomes non-empty; out_valid one cycle after mul_fin.
// Backpressure: in_ready drops when the FIFO is full; a single held result blocks new operations until consumed.
module sm_mul_driver #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy,
    output logic        err,
    output logic        mul_bgn,
    output logic [7:0]  mul_ibus,
    input  logic [7:0]  mul_obus,
    input  logic        mul_fin
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LDX,
        S_LDY,
        S_RUN
    } state_t;

    // Operand-pair FIFO storage and bookkeeping
    logic [7:0]    r_fx [DEPTH];
    logic [7:0]    r_fy [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;

    // Sequencer state and registered outputs
    state_t        r_state;
    logic [7:0]    r_opx;
    logic [7:0]    r_opy;
    logic [7:0]    r_lo;
    logic [TW-1:0] r_tcnt;
    logic          r_bgn;
    logic [7:0]    r_ibus;
    logic          r_out_valid;
    logic [15:0]   r_out_p;
    logic          r_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_cnt == FULL_CNT);
    assign w_empty = (r_cnt == '0);
    assign w_push  = in_valid & ~w_full;
    // A pair leaves the FIFO only as the sequencer launches it, and never while a result is still held
    assign w_pop   = (r_state == S_IDLE) & ~w_empty & ~r_out_valid;

    assign in_ready  = ~w_full;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;
    assign mul_bgn   = r_bgn;
    assign mul_ibus  = r_ibus;

    // FIFO data array: written on accept, contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fx[r_wptr] <= in_x;
            r_fy[r_wptr] <= in_y;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
        end
    end

    // Multiplier load/capture sequencer with result holding register and sticky timeout flag
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_opx       <= '0;
            r_opy       <= '0;
            r_lo        <= '0;
            r_tcnt      <= '0;
            r_bgn       <= 1'b0;
            r_ibus      <= '0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ibus <= '0;
                    if (w_pop) begin
                        r_opx   <= r_fx[r_rptr];
                        r_opy   <= r_fy[r_rptr];
                        r_bgn   <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_bgn   <= 1'b0;
                    r_ibus  <= r_opx;
                    r_state <= S_LDX;
                end
                S_LDX: begin
                    r_ibus  <= r_opy;
                    r_state <= S_LDY;
                end
                S_LDY: begin
                    r_ibus  <= '0;
                    r_tcnt  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // High byte arrives the cycle before fin, so the last capture is the high byte
                    r_lo <= mul_obus;
                    if (mul_fin) begin
                        r_out_p     <= {r_lo, mul_obus};
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_tcnt == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: begin
                    r_bgn   <= 1'b0;
                    r_ibus  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm_mul_driver.sv
// Scoreboard bench for sm_mul_driver with a behavioural multiplier that replays hand-computed product bytes.
// Latency: stimulus, multiplier model and result monitor run as separate processes.
// Backpressure: out_ready is driven per scenario to hold or drain results.
module tb_sm_mul_driver;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 31;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_p;
    logic        busy;
    logic        err;
    logic        mul_bgn;
    logic [7:0]  mul_ibus;
    logic [7:0]  mul_obus = '0;
    logic        mul_fin = 1'b0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] hi;
        logic [7:0] lo;
        int         d;
        bit         nofin;
    } op_t;

    op_t         mq[$];
    logic [15:0] eq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          abort_op = 1'b0;

    sm_mul_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .busy(busy), .err(err),
        .mul_bgn(mul_bgn), .mul_ibus(mul_ibus), .mul_obus(mul_obus), .mul_fin(mul_fin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [7:0] hi,
                        input logic [7:0] lo, input int d, input bit nofin);
        op_t op;
        int  w;
        op.x = x; op.y = y; op.hi = hi; op.lo = lo; op.d = d; op.nofin = nofin;
        in_x = x; in_y = y; in_valid = 1'b1; w = 0;
        while (!in_ready && w < 200) begin
            cyc(1);
            w++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL push_wait: in_ready=%0b required 1 within 200 cycles", in_ready);
        end else begin
            mq.push_back(op);
            if (!nofin) eq.push_back({hi, lo});
        end
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!out_valid && w < 200) begin
            cyc(1);
            w++;
        end
        chk("wait_valid", out_valid, 1);
    endtask

    task automatic wait_drain();
        int w = 0;
        out_ready = 1'b1;
        while ((eq.size() != 0 || mq.size() != 0 || busy || out_valid) && w < 500) begin
            cyc(1);
            w++;
        end
        chk("drain", {eq.size() == 0, mq.size() == 0, !busy, !out_valid}, 4'hF);
    endtask

    // Behavioural multiplier: checks the load sequence, then returns the queued product bytes
    initial begin : model
        op_t op;
        forever begin
            @(posedge clk);
            #1;
            if (rst_b && mul_bgn) begin
                abort_op = 1'b0;
                if (mq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_bgn: bgn=1 with no pending pair");
                end else begin
                    op = mq.pop_front();
                    chk("ibus_at_bgn", mul_ibus, 0);
                    cyc(1);
                    chk("bgn_one_cycle", mul_bgn, 0);
                    chk("ibus_x", mul_ibus, op.x);
                    cyc(1);
                    chk("ibus_y", mul_ibus, op.y);
                    cyc(1);
                    chk("ibus_run", mul_ibus, 0);
                    if (op.nofin) begin
                        cyc(TIMEOUT);
                        chk("err_before_timeout", err, 0);
                        cyc(1);
                        chk("err_after_timeout", err, 1);
                        chk("idle_after_timeout", busy, 0);
                    end else begin
                        cyc(op.d);
                        mul_obus = op.hi;
                        cyc(1);
                        mul_obus = op.lo;
                        mul_fin  = 1'b1;
                        cyc(1);
                        mul_obus = '0;
                        mul_fin  = 1'b0;
                        if (!abort_op) chk("valid_after_fin", out_valid, 1);
                    end
                end
            end
        end
    end

    // Result monitor: compares transfers against the scoreboard and checks held results stay stable
    initial begin : monitor
        logic        pv;
        logic        px;
        logic [15:0] pp;
        pv = 1'b0; px = 1'b0; pp = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                pv = 1'b0;
                px = 1'b0;
                continue;
            end
            if (pv && !px) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_p", out_p, pp);
            end
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result: out_p=%0h with nothing expected", out_p);
                end else begin
                    chk("result", out_p, eq.pop_front());
                end
            end
            pv = out_valid;
            pp = out_p;
            px = out_valid && out_ready;
        end
    end

    initial begin : watchdog
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin : stim
        int w;
        // Reset values while reset is held
        cyc(2);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_err", err, 0);
        chk("rst_bgn", mul_bgn, 0);
        chk("rst_ibus", mul_ibus, 0);
        chk("rst_busy", busy, 0);
        rst_b = 1'b1;
        cyc(2);

        // Single op: -23 * -3 = +69
        out_ready = 1'b0;
        push(8'h97, 8'h83, 8'h00, 8'h45, 0, 1'b0);
        cyc(1);
        chk("bgn_latency", mul_bgn, 1);
        wait_valid();
        chk("single_p", out_p, 16'h0045);
        cyc(3);
        chk("single_held", out_valid, 1);
        out_ready = 1'b1;
        cyc(1);
        chk("single_consumed", out_valid, 0);
        wait_drain();

        // Back-pressure: second op must wait for the first result to be taken
        out_ready = 1'b0;
        push(8'h03, 8'h02, 8'h00, 8'h06, 0, 1'b0);
        push(8'h85, 8'h84, 8'h00, 8'h14, 0, 1'b0);
        wait_valid();
        cyc(10);
        chk("bp_no_start", busy, 0);
        chk("bp_in_ready", in_ready, 1);
        chk("bp_first_p", out_p, 16'h0006);
        wait_drain();

        // FIFO full: first op stalls in RUN while two more fill the FIFO
        out_ready = 1'b1;
        push(8'h02, 8'h03, 8'h00, 8'h06, 12, 1'b0);
        push(8'h81, 8'h02, 8'h80, 8'h02, 0, 1'b0);
        push(8'h04, 8'h84, 8'h80, 8'h10, 0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        in_x = 8'hAA; in_y = 8'hBB; in_valid = 1'b1;
        cyc(2);
        chk("full_stays", in_ready, 0);
        in_valid = 1'b0;
        wait_drain();

        // Timeout, then a normal op with a mixed-sign product
        push(8'h11, 8'h22, 8'h00, 8'h00, 0, 1'b1);
        push(8'h05, 8'h83, 8'h80, 8'h0F, 0, 1'b0);
        wait_drain();
        chk("err_sticky", err, 1);

        // Reset in the middle of RUN
        push(8'h06, 8'h07, 8'h00, 8'h2A, 20, 1'b0);
        w = 0;
        while (!mul_bgn && w < 50) begin
            cyc(1);
            w++;
        end
        chk("mid_bgn_seen", mul_bgn, 1);
        cyc(5);
        rst_b = 1'b0;
        abort_op = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_p", out_p, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_err", err, 0);
        chk("mid_bgn", mul_bgn, 0);
        chk("mid_ibus", mul_ibus, 0);
        eq.delete();
        cyc(1);
        rst_b = 1'b1;
        cyc(40);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_valid", out_valid, 0);

        // Normal operation after reset: +127 * -1 = -127
        push(8'h7F, 8'h81, 8'h80, 8'h7F, 1, 1'b0);
        wait_drain();
        chk("post_rst_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sm_mul_driver.md
Name: sm_mul_driver

Overview:
Operand/result sequencer that wraps the 8-bit sign-magnitude multiplier unit.
- Accepts operand pairs (X, Y) from a host through a valid/ready handshake and buffers them in a small FIFO.
- Drives the multiplier's bgn/ibus load sequence and captures the two product bytes returned on obus.
- Presents the 16-bit sign-magnitude product to the host through a second valid/ready handshake.

Parameters:
DEPTH, 2, operand-pair FIFO depth (power of two, >=2).
TIMEOUT, 31, maximum cycles in RUN before the operation is aborted.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_b  input  1  asynchronous active-low reset
in_valid  input  1  host offers an operand pair
in_ready  output  1  FIFO not full; pair accepted when in_valid & in_ready
in_x  input  8  multiplicand, sign-magnitude (bit7 sign, bits6:0 magnitude)
in_y  input  8  multiplier, sign-magnitude
out_valid  output  1  out_p holds a product
out_ready  input  1  host consumes product when out_valid & out_ready
out_p  output  16  product {high byte, low byte}
busy  output  1  state != IDLE
err  output  1  sticky timeout flag
mul_bgn  output  1  start pulse to multiplier
mul_ibus  output  8  operand bus to multiplier
mul_obus  input  8  result bus from multiplier
mul_fin  input  1  multiplier done

Behaviour:
- Reset (async, rst_b=0) values:
  - FIFO empty; state=IDLE; in_ready=1; out_valid=0; out_p=0; err=0; mul_bgn=0; mul_ibus=0; timeout counter=0.
  - Reset mid-operation aborts immediately. The multiplier shares rst_b and resets with this block.
- FIFO:
  - Write on in_valid & in_ready. Pop occurs only on the IDLE->START transition.
  - in_ready = !full. Writes while full are ignored.
  - Simultaneous push and pop while full is not permitted, because in_ready=0.
  - Pointers wrap modulo DEPTH. Full/empty are derived from a count of width clog2(DEPTH)+1.
- Multiplier protocol (decided interface):
  - mul_bgn is high for exactly one cycle.
  - X is on mul_ibus in the cycle after bgn, and Y in the cycle after that.
  - The multiplier drives the product high byte on mul_obus one cycle, then the low byte the next cycle.
  - mul_fin is asserted in the low-byte cycle.
- FSM:
  - IDLE: mul_ibus=0. Go to START when FIFO not empty and out_valid=0. The pair is popped into the operand register on this transition.
  - START: mul_bgn=1, mul_ibus=0. Go to LDX.
  - LDX: mul_ibus=X. Go to LDY.
  - LDY: mul_ibus=Y. Go to RUN. Clear the timeout counter.
  - RUN: mul_ibus=0.
    - Each cycle, capture register lo<=mul_obus and hi<=lo.
    - If mul_fin: out_p<={lo_prev, mul_obus}, where lo_prev is the byte captured in the previous cycle. Set out_valid=1 and go to IDLE.
    - Else if counter==TIMEOUT: set err=1, leave out_valid unchanged, discard the pair, go to IDLE.
    - Else increment the counter.
  - Latency: FIFO non-empty with out_valid=0 gives mul_bgn in the next cycle. out_valid rises the cycle after mul_fin.
- Output handshake:
  - out_valid and out_p are held stable until out_valid & out_ready. On that transfer out_valid clears.
  - A new operation does not start while out_valid=1. This gives single-entry result back-pressure.
  - If out_ready is high in the same cycle out_valid rises, transfer occurs at the next edge.
- err:
  - Once set, err stays 1 until reset.
  - Operation continues with the next FIFO entry after a timeout.
- mul_fin outside RUN is ignored.

Test Plan:
- Single op: push X=8'h97 (-23), Y=8'h83 (-3); model obus hi=8'h00, lo=8'h45 with fin. Required: bgn one cycle, ibus sequence 00,97,83; out_p=16'h0045, out_valid=1 until out_ready.
- Back-pressure: two pairs pushed, out_ready=0. Required: second bgn does not occur until first result is consumed; in_ready stays 1 (DEPTH=2, one entry popped).
- FIFO full: push 3 pairs with multiplier stalled in RUN. Required: in_ready=0 after the third accepted push; the fourth push is ignored; all three results emerge in order.
- Timeout: model never asserts fin. Required: err=1 after TIMEOUT+1 RUN cycles; FSM returns to IDLE; next pair processes normally and err stays 1.
- Sign cases: X=8'h05, Y=8'h83 with modelled product 8'h80, 8'h0F. Required: out_p=16'h800F captured byte-exact.
- Reset mid-RUN: drop rst_b during RUN. Required: all outputs return to reset values asynchronously; FIFO empty; no out_valid after release.
